// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Raster timing generator for the pong renderer and the VGA pins.
//   Two phase FSMs (horizontal and vertical) step VISIBLE->FRONT->SYNC->BACK.
//   Every output is registered and derived from next-state values, so
//   position, blanking and sync change together in the same cycle.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset (wins over ce)
//   ce           in   1   pixel enable; state advances only when high
//   hpos         out  10  current pixel column, 0..H_TOTAL-1
//   vpos         out  10  current line, 0..V_TOTAL-1
//   de           out  1   display enable, high inside the visible area
//   hsync        out  1   horizontal sync, HSYNC_POL during H SYNC phase
//   vsync        out  1   vertical sync, VSYNC_POL during V SYNC phase
//   line_start   out  1   one-clk pulse when hpos becomes 0
//   frame_start  out  1   one-clk pulse when (hpos,vpos) becomes (0,0)
//   frame_count  out  8   frames started since reset, wraps 255->0
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FRONT_START = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_BACK_START  = 10'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FRONT_START = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BACK_START  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    PH_VISIBLE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  phase_e     h_state_q, h_state_d;
  phase_e     v_state_q, v_state_d;
  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       h_wrap;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // State register. Reset parks the raster on the last pixel of the frame
  // so the first enabled edge lands exactly on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      h_state_q     <= PH_BACK;
      v_state_q     <= PH_BACK;
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      de_q          <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state: counters and phases. Phase starts are tested latest-first
  // so a zero-width phase is skipped instead of getting stuck.
  always_comb begin
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_wrap    = (hpos_q == H_LAST);
    if (ce) begin
      hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;
      if (hpos_d == H_BACK_START)       h_state_d = PH_BACK;
      else if (hpos_d == H_SYNC_START)  h_state_d = PH_SYNC;
      else if (hpos_d == H_FRONT_START) h_state_d = PH_FRONT;
      else if (hpos_d == 10'd0)         h_state_d = PH_VISIBLE;

      // Vertical state only moves on a line wrap, so vsync edges align to hpos=0.
      if (h_wrap) begin
        vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        if (vpos_d == V_BACK_START)       v_state_d = PH_BACK;
        else if (vpos_d == V_SYNC_START)  v_state_d = PH_SYNC;
        else if (vpos_d == V_FRONT_START) v_state_d = PH_FRONT;
        else if (vpos_d == 10'd0)         v_state_d = PH_VISIBLE;
      end
    end
  end

  // Output decode from next-state. Strobes are gated with ce because the
  // position holds at 0 during ce=0 cycles and must not re-fire.
  always_comb begin
    de_d          = (h_state_d == PH_VISIBLE) && (v_state_d == PH_VISIBLE);
    hsync_d       = (h_state_d == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (v_state_d == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = ce && (hpos_d == 10'd0);
    frame_start_d = line_start_d && (vpos_d == 10'd0);
    frame_count_d = frame_count_q + {7'd0, frame_start_d};
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Self-checking bench for vga_sync_gen. Uses a shrunken raster
//   (15 x 11, 165 pixels per frame) so many whole frames fit in a short run.
//   Expected outputs come from a fixed vector table and from a model that
//   derives every output from the count of enabled edges since reset.
module tb_vga_sync_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [9:0] hpos, vpos;
  logic       de, hsync, vsync, line_start, frame_start;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  // Model state: enabled edges since reset, and whether the last edge advanced.
  int n_adv = 0;
  bit last_adv = 1'b0;

  typedef struct {
    int hpos, vpos, de, hs, vs, ls, fs, fc;
  } out_t;

  typedef struct {
    bit   rst;
    bit   en;
    out_t exp;
  } vec_t;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hpos(hpos), .vpos(vpos), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Position is simply the enabled-edge index modulo the frame size.
  function automatic out_t modelOut();
    out_t o;
    int   idx;
    if (n_adv == 0) begin
      o = '{HT - 1, VT - 1, 0, 1, 1, 0, 0, 0};
    end else begin
      idx    = (n_adv - 1) % FRAME;
      o.hpos = idx % HT;
      o.vpos = idx / HT;
      o.de   = (o.hpos < HV && o.vpos < VV) ? 1 : 0;
      o.hs   = (o.hpos >= HV + HF && o.hpos < HV + HF + HS) ? 0 : 1;
      o.vs   = (o.vpos >= VV + VF && o.vpos < VV + VF + VS) ? 0 : 1;
      o.ls   = (last_adv && o.hpos == 0) ? 1 : 0;
      o.fs   = (last_adv && idx == 0) ? 1 : 0;
      o.fc   = ((n_adv - 1) / FRAME + 1) % 256;
    end
    return o;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input out_t e);
    checkVal({tag, ".hpos"}, int'(hpos), e.hpos);
    checkVal({tag, ".vpos"}, int'(vpos), e.vpos);
    checkVal({tag, ".de"}, int'(de), e.de);
    checkVal({tag, ".hsync"}, int'(hsync), e.hs);
    checkVal({tag, ".vsync"}, int'(vsync), e.vs);
    checkVal({tag, ".line_start"}, int'(line_start), e.ls);
    checkVal({tag, ".frame_start"}, int'(frame_start), e.fs);
    checkVal({tag, ".frame_count"}, int'(frame_count), e.fc);
  endtask

  // Drive on the falling edge, clock once, then sample 1 time unit later.
  task automatic applyStimulus(input bit rst, input bit en);
    @(negedge clk);
    reset = rst;
    ce    = en;
    @(posedge clk);
    if (rst) begin
      n_adv    = 0;
      last_adv = 1'b0;
    end else begin
      if (en) n_adv++;
      last_adv = en;
    end
    #1;
  endtask

  vec_t vecs[8];
  out_t m;

  initial begin
    vecs[0] = '{1'b1, 1'b0, '{14, 10, 0, 1, 1, 0, 0, 0}};
    vecs[1] = '{1'b1, 1'b1, '{14, 10, 0, 1, 1, 0, 0, 0}};
    vecs[2] = '{1'b1, 1'b1, '{14, 10, 0, 1, 1, 0, 0, 0}};
    vecs[3] = '{1'b0, 1'b1, '{0, 0, 1, 1, 1, 1, 1, 1}};
    vecs[4] = '{1'b0, 1'b0, '{0, 0, 1, 1, 1, 0, 0, 1}};
    vecs[5] = '{1'b0, 1'b1, '{1, 0, 1, 1, 1, 0, 0, 1}};
    vecs[6] = '{1'b0, 1'b0, '{1, 0, 1, 1, 1, 0, 0, 1}};
    vecs[7] = '{1'b0, 1'b1, '{2, 0, 1, 1, 1, 0, 0, 1}};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Walk to the last visible pixel and into front porch and hsync.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    checkVal("hand.last_visible_hpos", int'(hpos), HV - 1);
    checkVal("hand.last_visible_de", int'(de), 1);
    applyStimulus(1'b0, 1'b1);
    checkVal("hand.front_de", int'(de), 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1);
    checkVal("hand.hsync_start_hpos", int'(hpos), HV + HF);
    checkVal("hand.hsync_start_level", int'(hsync), 0);

    // Random enable pattern against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(1'b0, 1'(($urandom % 4) != 0));
      m = modelOut();
      checkOutput("rand", m);
    end

    // Alternating enable: outputs hold across ce=0 and strobes stay one clk.
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      applyStimulus(1'b0, 1'(i % 2));
      m = modelOut();
      checkOutput("toggle", m);
    end

    // Reset in the middle of vsync with hsync active.
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < (VV + VF + 1) * HT + HV + HF + 2; i++) applyStimulus(1'b0, 1'b1);
    checkVal("midvs.hpos", int'(hpos), HV + HF + 1);
    checkVal("midvs.vpos", int'(vpos), VV + VF + 1);
    checkVal("midvs.vsync_active", int'(vsync), 0);
    checkVal("midvs.hsync_active", int'(hsync), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midvs_reset", '{14, 10, 0, 1, 1, 0, 0, 0});

    // 256 frames at full rate, every cycle against the model.
    for (int i = 0; i < 256 * FRAME + 2; i++) begin
      applyStimulus(1'b0, 1'b1);
      m = modelOut();
      checkOutput("frames", m);
      if (n_adv == 255 * FRAME + 1) begin
        checkVal("wrap256.frame_start", int'(frame_start), 1);
        checkVal("wrap256.frame_count", int'(frame_count), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
